demux_deser8: RTL and testbench
===============================

Name: demux_deser8

Overview:
- Serial-to-parallel deserializer: the inverse of the 4:1 selection path used in the barrel-shifter datapath.
- Accepts one data bit per cycle under a valid/ready handshake and steers each bit into the slot of a parallel word chosen by an internal slot counter.
- Presents each completed word through a one-entry output buffer with its own valid/ready handshake.
- Used by the DCE shifter experiments to feed 8-bit operands from a serial source.

Parameters:
- WIDTH, 8, number of bits per assembled word (legal range 2..32).
- MSB_FIRST, 0, 0: first accepted bit lands in bit 0; 1: first accepted bit lands in bit WIDTH-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- align  input  1  synchronous frame realign; discards the partial word and restarts at slot 0.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  block can accept in_bit this cycle.
- out_data  output  WIDTH  assembled word, stable while out_valid=1.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data this cycle.
- fill_cnt  output  log2(WIDTH)+1  number of bits in the current partial word, 0..WIDTH-1.

Behaviour:
- Reset (rst=1 at an edge): out_data=0, out_valid=0, fill_cnt=0, partial register=0. in_ready reads 1 in the first cycle after reset. Reset has priority over align and over all handshakes. A partial word in progress is discarded.
- Accept rule: a bit is accepted when in_valid=1 and in_ready=1.
- Slot selection: slot = fill_cnt when MSB_FIRST=0, else WIDTH-1-fill_cnt. The accepted bit is written to that slot of the partial register; other slots hold.
- Counter: fill_cnt increments on each accept. It wraps to 0 on the accept at fill_cnt=WIDTH-1, which is the completing accept.
- Completing accept: the full word (the partial register with the final bit merged in) is loaded into out_data, out_valid=1 on the next cycle, and the partial register clears to 0. Latency is 1 cycle from the last bit's accept edge to out_valid.
- Output handshake: out_valid clears when out_valid=1 and out_ready=1 at an edge, unless a completing accept occurs in the same cycle. In that case out_data is replaced by the new word and out_valid stays 1, giving back-to-back words with no bubble.
- in_ready = 0 only when fill_cnt=WIDTH-1 and out_valid=1 and out_ready=0. Otherwise it is 1. in_ready is combinational from state and out_ready, with no path from in_valid.
- Partial collection of the next word (fill_cnt 0..WIDTH-2) continues while the output buffer is held.
- align=1 at an edge: fill_cnt=0 and the partial register clears. Any bit presented in the same cycle is dropped, even if in_valid=1 and in_ready=1. out_data and out_valid are unaffected, and the output handshake proceeds normally that cycle.
- in_valid=0: no state change in the deserializer path.
- out_data never changes while out_valid=1 and out_ready=0.
- Control structure: state is {fill_cnt, buffer-full flag}.
  - EMPTY_COLLECT (out_valid=0) goes to FULL_COLLECT on a completing accept.
  - FULL_COLLECT goes to EMPTY_COLLECT on a drain without a completing accept.
  - FULL_STALL is FULL_COLLECT with fill_cnt=WIDTH-1 and out_ready=0; it holds.

Test Plan:
- Reset, then LSB-first (MSB_FIRST=0), feed 1,0,1,1,0,0,1,0 with in_valid=1 continuously and out_ready=1 -> out_data=8'h4D with out_valid=1 for exactly one cycle, 1 cycle after the 8th accept; fill_cnt steps 0..7 then returns to 0.
- Same bits with MSB_FIRST=1 -> out_data=8'hB2.
- Backpressure: out_ready=0, feed 16 bits forming 8'hA5 then 8'h3C -> out_data holds 8'hA5. After 15 accepts, fill_cnt=7 and in_ready=0; the 16th bit stalls. Raise out_ready -> the 16th bit is accepted that cycle, out_data=8'h3C next cycle, and out_valid stays 1.
- Feed 5 bits, pulse align with in_valid=1, then feed 8 bits forming 8'hFF -> the in_valid bit during align is dropped, and out_data=8'hFF with no stale bits from the aborted word.
- Apply rst mid-word (fill_cnt=3) while out_valid=1 -> next cycle out_valid=0, out_data=0, fill_cnt=0, in_ready=1.
- Random in_valid and out_ready over 1000 words -> scoreboard matches every word in order, with no loss and no duplication.

Source files
------------

// File: rtl/demux_deser8.sv
// Serial-to-parallel deserializer: one bit per accept, steered by a slot
// counter, completed words held in a one-entry output buffer.
module demux_deser8 #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     align,
  input  logic                     in_bit,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH):0]   fill_cnt
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = IW + 1;

  typedef enum logic {
    EMPTY_COLLECT = 1'b0,
    FULL_COLLECT  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             last;
  logic             acc;
  logic             cmpl;
  logic             drain;
  logic [IW-1:0]    slot;
  logic [WIDTH-1:0] merged;

  always_comb begin
    last     = (fill_q == CW'(WIDTH - 1));
    drain    = (state_q == FULL_COLLECT) && out_ready;
    // Only the completing bit can stall, and only if the buffer won't drain.
    in_ready = !(last && (state_q == FULL_COLLECT) && !out_ready);
    acc      = in_valid && in_ready && !align;
    cmpl     = acc && last;

    if (MSB_FIRST) begin
      slot = IW'(WIDTH - 1) - fill_q[IW-1:0];
    end else begin
      slot = fill_q[IW-1:0];
    end

    merged       = part_q;
    merged[slot] = in_bit;
  end

  always_comb begin
    fill_d  = fill_q;
    part_d  = part_q;
    data_d  = data_q;
    state_d = state_q;

    if (align) begin
      fill_d = '0;
      part_d = '0;
    end else if (acc) begin
      if (last) begin
        fill_d = '0;
        part_d = '0;
      end else begin
        fill_d = fill_q + CW'(1);
        part_d = merged;
      end
    end

    unique case (state_q)
      EMPTY_COLLECT: begin
        if (cmpl) begin
          data_d  = merged;
          state_d = FULL_COLLECT;
        end
      end
      FULL_COLLECT: begin
        // A completing accept alongside a drain refills with no bubble.
        if (cmpl) begin
          data_d  = merged;
          state_d = FULL_COLLECT;
        end else if (drain) begin
          state_d = EMPTY_COLLECT;
        end
      end
      default: state_d = EMPTY_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY_COLLECT;
      fill_q  <= '0;
      part_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      part_q  <= part_d;
      data_q  <= data_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = (state_q == FULL_COLLECT);
  assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_demux_deser8.sv
// Directed and scoreboarded checks for demux_deser8, LSB- and MSB-first.
module tb_demux_deser8;

  logic       clk = 1'b0;
  logic       rst;
  logic       align;
  logic       in_bit;
  logic       in_valid;
  logic       out_ready;

  logic       rdy0, rdy1;
  logic [7:0] dat0, dat1;
  logic       vld0, vld1;
  logic [3:0] cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  demux_deser8 #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .align(align),
    .in_bit(in_bit), .in_valid(in_valid), .in_ready(rdy0),
    .out_data(dat0), .out_valid(vld0), .out_ready(out_ready),
    .fill_cnt(cnt0)
  );

  demux_deser8 #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .align(align),
    .in_bit(in_bit), .in_valid(in_valid), .in_ready(rdy1),
    .out_data(dat1), .out_valid(vld1), .out_ready(out_ready),
    .fill_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic feed(input logic b);
    in_bit = b;
    tick();
  endtask

  initial begin
    logic [7:0]  v8;
    logic [15:0] v16;
    logic [7:0]  expq[$];
    logic [7:0]  cur;
    int          idx, made, seen, cyc;
    logic [3:0]  m_fill;
    logic        m_full, m_rdy, acc, cmpl;

    rst = 1'b1; align = 1'b0; in_bit = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_vld", {31'b0, vld0}, 32'd0);
    chk("rst_dat", {24'b0, dat0}, 32'd0);
    chk("rst_cnt", {28'b0, cnt0}, 32'd0);
    chk("rst_rdy", {31'b0, rdy0}, 32'd1);

    // 1,0,1,1,0,0,1,0 in arrival order
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    v8 = 8'h4D;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("cnt_step%0d", i), {28'b0, cnt0}, i);
      chk($sformatf("vld_lo%0d", i), {31'b0, vld0}, 32'd0);
      feed(v8[i]);
    end
    chk("lsb_vld", {31'b0, vld0}, 32'd1);
    chk("lsb_dat", {24'b0, dat0}, 32'h4D);
    chk("msb_dat", {24'b0, dat1}, 32'hB2);
    chk("wrap_cnt", {28'b0, cnt0}, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("one_cyc", {31'b0, vld0}, 32'd0);

    // Backpressure: A5 then 3C with consumer stalled
    out_ready = 1'b0; in_valid = 1'b1;
    v16 = {8'h3C, 8'hA5};
    for (int i = 0; i < 15; i++) feed(v16[i]);
    #1;
    chk("bp_cnt", {28'b0, cnt0}, 32'd7);
    chk("bp_rdy", {31'b0, rdy0}, 32'd0);
    chk("bp_dat", {24'b0, dat0}, 32'hA5);
    feed(v16[15]);
    chk("bp_hold_cnt", {28'b0, cnt0}, 32'd7);
    chk("bp_hold_dat", {24'b0, dat0}, 32'hA5);
    chk("bp_hold_vld", {31'b0, vld0}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_up", {31'b0, rdy0}, 32'd1);
    tick();
    chk("b2b_dat", {24'b0, dat0}, 32'h3C);
    chk("b2b_vld", {31'b0, vld0}, 32'd1);
    chk("b2b_cnt", {28'b0, cnt0}, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", {31'b0, vld0}, 32'd0);

    // Align drops the in-flight bit and the partial word
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) feed(1'b1);
    chk("al_pre", {28'b0, cnt0}, 32'd5);
    align = 1'b1;
    feed(1'b1);
    align = 1'b0;
    chk("al_cnt", {28'b0, cnt0}, 32'd0);
    for (int i = 0; i < 7; i++) feed(1'b1);
    chk("al_notyet", {31'b0, vld0}, 32'd0);
    feed(1'b1);
    chk("al_ff_vld", {31'b0, vld0}, 32'd1);
    chk("al_ff_dat", {24'b0, dat0}, 32'hFF);
    for (int i = 0; i < 3; i++) feed(1'b1);
    align = 1'b1;
    feed(1'b1);
    align = 1'b0;
    for (int i = 0; i < 8; i++) feed(1'b0);
    chk("al_stale", {24'b0, dat0}, 32'h00);
    in_valid = 1'b0;
    tick();

    // Reset mid-word with a word buffered
    out_ready = 1'b0; in_valid = 1'b1;
    v8 = 8'h5A;
    for (int i = 0; i < 8; i++) feed(v8[i]);
    for (int i = 0; i < 3; i++) feed(1'b1);
    chk("mr_vld", {31'b0, vld0}, 32'd1);
    chk("mr_cnt", {28'b0, cnt0}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mr_vld0", {31'b0, vld0}, 32'd0);
    chk("mr_dat0", {24'b0, dat0}, 32'd0);
    chk("mr_cnt0", {28'b0, cnt0}, 32'd0);
    chk("mr_rdy1", {31'b0, rdy0}, 32'd1);

    // Random handshakes, scoreboard of 1000 words
    m_fill = '0; m_full = 1'b0;
    cur = 8'($urandom); idx = 0; made = 0; seen = 0; cyc = 0;
    while ((made < 1000 || expq.size() != 0) && cyc < 60000) begin
      in_valid  = (made < 1000) ? 1'($urandom) : 1'b0;
      out_ready = 1'($urandom);
      in_bit    = cur[idx];
      m_rdy = !(m_fill == 4'd7 && m_full && !out_ready);
      #1;
      if (rdy0 !== m_rdy) chk("rnd_rdy", {31'b0, rdy0}, {31'b0, m_rdy});
      if (vld0 !== m_full) chk("rnd_vld", {31'b0, vld0}, {31'b0, m_full});
      acc  = in_valid && m_rdy;
      cmpl = acc && (m_fill == 4'd7);
      if (m_full && out_ready) begin
        chk($sformatf("rnd_w%0d", seen), {24'b0, dat0},
            {24'b0, expq.pop_front()});
        seen++;
      end
      if (acc) begin
        idx++;
        m_fill = cmpl ? 4'd0 : m_fill + 4'd1;
      end
      if (cmpl) begin
        expq.push_back(cur);
        made++;
        cur = 8'($urandom);
        idx = 0;
      end
      m_full = cmpl ? 1'b1 : ((m_full && out_ready) ? 1'b0 : m_full);
      cyc++;
      tick();
    end
    chk("rnd_count", seen, 32'd1000);
    chk("rnd_left", expq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
